icache_ctrl: RTL

Direct-mapped instruction-cache controller sitting between the IF stage and the synchronous instruction ROM (one-cycle read latency, word-addressed). It serves hits combinationally and refills whole lines from the ROM through a small refill state machine. While a refill is in progress it stalls the fetch stage. It also keeps access and miss counters for the cache bonus evaluation.

---
 rtl/icache_ctrl.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/icache_ctrl.sv
// ---------------------------------------------------------------------------
// icache_ctrl
//
// Direct-mapped instruction-cache controller between the IF stage and a
// synchronous, word-addressed instruction ROM with one-cycle read latency.
// Hits are served combinationally in the request cycle. A miss starts a
// refill that reads the whole line from the ROM and stalls fetch until the
// line is valid. The request is then served in the following IDLE cycle.
//
// Ports
//   clk, rst    : clock; asynchronous active-high reset
//   cpu_req     : fetch request valid
//   cpu_addr    : byte address (bits [1:0] ignored)
//   cpu_stall   : request not served this cycle
//   cpu_data    : instruction, valid when cpu_req && !cpu_stall
//   flush       : single-cycle pulse, invalidates every line
//   rom_addr    : word address presented to the ROM
//   rom_dout    : ROM data for the address presented on the previous cycle
//   access_cnt  : served accesses (wraps at 2^32)
//   miss_cnt    : refills started (wraps at 2^32)
// ---------------------------------------------------------------------------
module icache_ctrl #(
  parameter int LINE_WORDS = 4,
  parameter int LINES      = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic [31:0] cpu_addr,
  output logic        cpu_stall,
  output logic [31:0] cpu_data,
  input  logic        flush,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_dout,
  output logic [31:0] access_cnt,
  output logic [31:0] miss_cnt
);

  localparam int OFF_W  = $clog2(LINE_WORDS);
  localparam int IDX_W  = $clog2(LINES);
  localparam int LINE_W = 30 - OFF_W;           // word address without offset
  localparam int TAG_W  = LINE_W - IDX_W;
  localparam int CNT_W  = $clog2(LINE_WORDS + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LINE_WORDS);
  localparam logic [OFF_W-1:0] OFF_LAST = OFF_W'(LINE_WORDS - 1);

  typedef enum logic {
    IDLE,
    REFILL
  } state_t;

  // Registered state
  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [LINE_W-1:0]       line_q, line_d;      // latched miss line (word addr / LINE_WORDS)
  logic                    flush_pend_q, flush_pend_d;
  logic [31:0]             access_q, access_d;
  logic [31:0]             miss_q, miss_d;
  logic [LINES-1:0]        valid_q, valid_d;
  logic [TAG_W-1:0]        tag_q  [LINES];
  logic [31:0]             data_q [LINES][LINE_WORDS];

  // Request address decode
  logic [29:0]             w;
  logic [OFF_W-1:0]        req_off;
  logic [IDX_W-1:0]        req_idx;
  logic [TAG_W-1:0]        req_tag;
  logic                    hit;

  // Refill line decode
  logic [IDX_W-1:0]        fill_idx;
  logic [TAG_W-1:0]        fill_tag;
  logic [OFF_W-1:0]        rom_off;

  // Array write controls
  logic                    wr_en;
  logic [OFF_W-1:0]        wr_off;
  logic                    fill_done;

  // Byte-lane bits of the fetch address carry no information.
  logic                    unused_addr_bits;
  assign unused_addr_bits = ^cpu_addr[1:0];

  assign w        = cpu_addr[31:2];
  assign req_off  = w[OFF_W-1:0];
  assign req_idx  = w[OFF_W +: IDX_W];
  assign req_tag  = w[29 -: TAG_W];
  assign hit      = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

  assign fill_idx = line_q[IDX_W-1:0];
  assign fill_tag = line_q[LINE_W-1 -: TAG_W];

  assign access_cnt = access_q;
  assign miss_cnt   = miss_q;

  // ROM word offset saturates at the last word: the final REFILL cycle only
  // captures data already requested, so the address simply holds.
  assign rom_off = (cnt_q >= CNT_LAST) ? OFF_LAST : cnt_q[OFF_W-1:0];

  // NOTE: every signal written here gets a default first so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    line_d       = line_q;
    flush_pend_d = flush_pend_q;
    access_d     = access_q;
    miss_d       = miss_q;
    valid_d      = valid_q;
    cpu_stall    = 1'b0;
    cpu_data     = '0;
    rom_addr     = '0;
    wr_en        = 1'b0;
    wr_off       = '0;
    fill_done    = 1'b0;

    unique case (state_q)
      IDLE: begin
        // The request is judged against the pre-flush valid bits.
        if (flush) valid_d = '0;
        if (cpu_req) begin
          if (hit) begin
            cpu_data = data_q[req_idx][req_off];
            access_d = access_q + 32'd1;
          end else begin
            cpu_stall = 1'b1;
            line_d    = w[29:OFF_W];
            miss_d    = miss_q + 32'd1;
            cnt_d     = '0;
            state_d   = REFILL;
          end
        end
      end

      REFILL: begin
        cpu_stall    = 1'b1;
        rom_addr     = {2'b00, line_q, rom_off};
        flush_pend_d = flush_pend_q | flush;
        cnt_d        = cnt_q + CNT_W'(1);
        // ROM data lags the address by one cycle, so count n writes word n-1.
        if (cnt_q != '0) begin
          wr_en  = 1'b1;
          wr_off = OFF_W'(cnt_q - CNT_W'(1));
        end
        if (cnt_q == CNT_LAST) begin
          state_d   = IDLE;
          cnt_d     = '0;
          fill_done = 1'b1;
          // A flush seen at any point during the refill also kills the new line.
          if (flush_pend_q || flush) begin
            valid_d      = '0;
            flush_pend_d = 1'b0;
          end else begin
            valid_d[fill_idx] = 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      line_q       <= '0;
      flush_pend_q <= 1'b0;
      access_q     <= '0;
      miss_q       <= '0;
      valid_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      line_q       <= line_d;
      flush_pend_q <= flush_pend_d;
      access_q     <= access_d;
      miss_q       <= miss_d;
      valid_q      <= valid_d;
    end
  end

  // NOTE: tag and data arrays are not reset; the valid bits alone decide
  // whether their contents are ever used, so a reset here would only cost area.
  always_ff @(posedge clk) begin
    if (wr_en)     data_q[fill_idx][wr_off] <= rom_dout;
    if (fill_done) tag_q[fill_idx]          <= fill_tag;
  end

endmodule
